apb_regfile_completer: RTL and testbench

APB4 completer (slave) that terminates the bus driven by the team's APB source blocks and exposes a small memory-mapped register bank to the surrounding design. It decodes each transfer, inserts a parameterizable number of wait states, applies byte strobes to writes, and flags decode and permission errors on PSLVERR. A read-only transfer counter gives benches and software a way to confirm that every completed access reached the completer.

---
 rtl/apb_regfile_completer.sv | 158 +++++++++++++++
 tb/tb_apb_regfile_completer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_completer.sv
// APB4 completer with a small scratch register bank, ID and transfer-count registers.
// Transfers are decoded at setup, held for WAIT_STATES cycles, and committed on the completion edge.
module apb_regfile_completer #(
  parameter int          ADDR_W      = 12,
  parameter int          DATA_W      = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          paddr,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [DATA_W-1:0]          pwdata,
  input  logic [3:0]                 pstrb,
  input  logic [2:0]                 pprot,
  output logic [DATA_W-1:0]          prdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [DATA_W*NUM_REGS-1:0] reg_out
);

  localparam int              IDX_W   = ADDR_W - 2;
  localparam logic [IDX_W-1:0] CNT_IDX = IDX_W'(NUM_REGS + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic [DATA_W-1:0] scratch [NUM_REGS];
  logic [31:0]       xfer_cnt;
  logic [3:0]        wait_cnt;

  logic [IDX_W-1:0]  widx_p0;
  logic              wr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [3:0]        strb_p0;
  logic [DATA_W-1:0] rdata_p0;
  logic              err_p0;

  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] dec_rdata;
  logic              dec_err;

  // Protection attributes carry no meaning for this register bank.
  logic unused_pprot;
  assign unused_pprot = ^pprot;

  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] old,
                                                   input logic [DATA_W-1:0] nw,
                                                   input logic [3:0]        s);
    logic [DATA_W-1:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (s[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  assign idx = paddr[ADDR_W-1:2];

  always_comb begin
    dec_rdata = '0;
    dec_err   = 1'b0;
    if (paddr[1:0] != 2'b00) begin
      dec_err = 1'b1;
    end else if (idx == '0) begin
      if (pwrite) dec_err = 1'b1;
      else        dec_rdata = ID_VALUE;
    end else if (idx == CNT_IDX) begin
      if (pwrite) dec_err = 1'b1;
      else        dec_rdata = xfer_cnt;
    end else if (idx > CNT_IDX) begin
      dec_err = 1'b1;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (idx == IDX_W'(i + 1)) dec_rdata = scratch[i];
    end
    // Writes and errored transfers always return zero data.
    if (pwrite || dec_err) dec_rdata = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pready   <= 1'b0;
      prdata   <= '0;
      pslverr  <= 1'b0;
      xfer_cnt <= '0;
      wait_cnt <= '0;
      widx_p0  <= '0;
      wr_p0    <= 1'b0;
      wdata_p0 <= '0;
      strb_p0  <= '0;
      rdata_p0 <= '0;
      err_p0   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) scratch[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          pready  <= 1'b0;
          prdata  <= '0;
          pslverr <= 1'b0;
          // Setup phase: capture and decode the whole transfer.
          if (psel && !penable) begin
            state    <= ACCESS;
            widx_p0  <= idx;
            wr_p0    <= pwrite;
            wdata_p0 <= pwdata;
            strb_p0  <= pstrb;
            rdata_p0 <= dec_rdata;
            err_p0   <= dec_err;
            wait_cnt <= 4'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              pready  <= 1'b1;
              prdata  <= dec_rdata;
              pslverr <= dec_err;
            end
          end
        end
        ACCESS: begin
          if (!psel) begin
            state   <= IDLE;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
          end else if (pready && penable) begin
            // Completion edge: commit the write and count the transfer.
            state   <= IDLE;
            pready  <= 1'b0;
            prdata  <= '0;
            pslverr <= 1'b0;
            if (!err_p0) begin
              xfer_cnt <= xfer_cnt + 32'd1;
              if (wr_p0)
                for (int i = 0; i < NUM_REGS; i++)
                  if (widx_p0 == IDX_W'(i + 1))
                    scratch[i] <= apply_strb(scratch[i], wdata_p0, strb_p0);
            end
          end else if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) begin
              pready  <= 1'b1;
              prdata  <= rdata_p0;
              pslverr <= err_p0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regout
    assign reg_out[DATA_W*g +: DATA_W] = scratch[g];
  end

endmodule

// File: tb/tb_apb_regfile_completer.sv
// Directed bench: three completers (0, 3 and 2 wait states) share bus inputs and reset,
// each with its own psel; a vector table plus hand sequences for abort and mid-transfer reset.
module tb_apb_regfile_completer;

  logic              clk = 1'b0;
  logic              rst;
  logic [11:0]       paddr;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [2:0]        pprot;
  logic [2:0]        psel_v;
  logic [2:0]        pready_v;
  logic [2:0]        pslverr_v;
  logic [2:0][31:0]  prdata_v;
  logic [2:0][255:0] regout_v;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb_regfile_completer #(.WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_v[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata_v[0]), .pready(pready_v[0]), .pslverr(pslverr_v[0]), .reg_out(regout_v[0]));

  apb_regfile_completer #(.WAIT_STATES(3)) u_w3 (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_v[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata_v[1]), .pready(pready_v[1]), .pslverr(pslverr_v[1]), .reg_out(regout_v[1]));

  apb_regfile_completer #(.WAIT_STATES(2)) u_w2 (
    .clk(clk), .rst(rst), .paddr(paddr), .psel(psel_v[2]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata_v[2]), .pready(pready_v[2]), .pslverr(pslverr_v[2]), .reg_out(regout_v[2]));

  typedef struct {
    int          inst;
    logic [11:0] a;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] erd;
    logic        eer;
    int          ew;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic xfer(input int inst, input logic [11:0] a, input logic w,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic er, output int waits,
                      output logic idle_bad);
    logic done;
    @(posedge clk); #1;
    paddr = a; pwrite = w; pwdata = d; pstrb = s; penable = 1'b0;
    psel_v[inst] = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    waits = 0; done = 1'b0; idle_bad = 1'b0; rd = '0; er = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (pready_v[inst]) begin
        rd = prdata_v[inst]; er = pslverr_v[inst]; done = 1'b1;
      end else begin
        if (prdata_v[inst] != 32'd0 || pslverr_v[inst]) idle_bad = 1'b1;
        waits++;
        @(posedge clk); #1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: inst %0d addr %03h no pready within 40 cycles", inst, a);
    end
    @(posedge clk); #1;
    psel_v[inst] = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          waits;
    logic        idle_bad;
    logic        bad;

    // inst 0: zero wait states
    tbl[0]  = '{0, 12'h000, 1'b0, 32'h0,         4'hF, 32'hA9B0_0001, 1'b0, 0};
    tbl[1]  = '{0, 12'h004, 1'b1, 32'h1111_1111, 4'hF, 32'h0,         1'b0, 0};
    tbl[2]  = '{0, 12'h004, 1'b1, 32'hDEAD_BEEF, 4'h5, 32'h0,         1'b0, 0};
    tbl[3]  = '{0, 12'h004, 1'b0, 32'h0,         4'h0, 32'h11AD_11EF, 1'b0, 0};
    tbl[4]  = '{0, 12'h000, 1'b1, 32'h5555_5555, 4'hF, 32'h0,         1'b1, 0};
    tbl[5]  = '{0, 12'h006, 1'b0, 32'h0,         4'hF, 32'h0,         1'b1, 0};
    tbl[6]  = '{0, 12'h800, 1'b0, 32'h0,         4'hF, 32'h0,         1'b1, 0};
    tbl[7]  = '{0, 12'h024, 1'b0, 32'h0,         4'hF, 32'd4,         1'b0, 0};
    tbl[8]  = '{0, 12'h008, 1'b1, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0, 0};
    tbl[9]  = '{0, 12'h008, 1'b0, 32'h0,         4'hF, 32'h0,         1'b0, 0};
    tbl[10] = '{0, 12'h028, 1'b0, 32'h0,         4'hF, 32'h0,         1'b1, 0};
    tbl[11] = '{0, 12'h024, 1'b1, 32'h0000_0001, 4'hF, 32'h0,         1'b1, 0};
    tbl[12] = '{0, 12'h024, 1'b0, 32'h0,         4'hF, 32'd7,         1'b0, 0};
    tbl[13] = '{0, 12'h024, 1'b0, 32'h0,         4'hF, 32'd8,         1'b0, 0};
    // inst 1: three wait states, five good transfers then two counter reads
    tbl[14] = '{1, 12'h008, 1'b1, 32'h0000_00A5, 4'hF, 32'h0,         1'b0, 3};
    tbl[15] = '{1, 12'h008, 1'b0, 32'h0,         4'hF, 32'h0000_00A5, 1'b0, 3};
    tbl[16] = '{1, 12'h00C, 1'b1, 32'h1234_5678, 4'hF, 32'h0,         1'b0, 3};
    tbl[17] = '{1, 12'h00C, 1'b0, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 3};
    tbl[18] = '{1, 12'h000, 1'b0, 32'h0,         4'hF, 32'hA9B0_0001, 1'b0, 3};
    tbl[19] = '{1, 12'h024, 1'b0, 32'h0,         4'hF, 32'd5,         1'b0, 3};
    tbl[20] = '{1, 12'h024, 1'b0, 32'h0,         4'hF, 32'd6,         1'b0, 3};

    rst = 1'b1; paddr = '0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    pstrb = '0; pprot = 3'b010; psel_v = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_pready%0d", i),  {31'd0, pready_v[i]},  32'd0);
      chk($sformatf("reset_prdata%0d", i),  prdata_v[i],           32'd0);
      chk($sformatf("reset_pslverr%0d", i), {31'd0, pslverr_v[i]}, 32'd0);
      chk($sformatf("reset_regout%0d", i),  {31'd0, |regout_v[i]}, 32'd0);
    end

    for (int i = 0; i < 21; i++) begin
      xfer(tbl[i].inst, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].s, rd, er, waits, idle_bad);
      chk($sformatf("v%0d_rdata", i), rd, tbl[i].erd);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, tbl[i].eer});
      chk($sformatf("v%0d_waits", i), waits, tbl[i].ew);
      chk($sformatf("v%0d_quiet_while_wait", i), {31'd0, idle_bad}, 32'd0);
      if (i == 3) chk("regout0_after_strb", regout_v[0][31:0], 32'h11AD_11EF);
      if (i == 16) chk("regout1_reg2", regout_v[1][95:64], 32'h1234_5678);
    end

    // Abort on inst 2: psel drops during ACCESS, pready must never rise.
    @(posedge clk); #1;
    paddr = 12'h004; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; penable = 1'b0;
    psel_v[2] = 1'b1;
    @(posedge clk); #1;
    psel_v[2] = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (pready_v[2]) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort_no_pready", {31'd0, bad}, 32'd0);
    chk("abort_no_write", regout_v[2][31:0], 32'd0);
    xfer(2, 12'h024, 1'b0, 32'h0, 4'hF, rd, er, waits, idle_bad);
    chk("abort_not_counted", rd, 32'd0);
    chk("w2_waits", waits, 2);

    xfer(2, 12'h004, 1'b1, 32'h1234_5678, 4'hF, rd, er, waits, idle_bad);
    chk("w2_prewrite", regout_v[2][31:0], 32'h1234_5678);

    // Reset in the middle of a write's access phase on inst 2.
    @(posedge clk); #1;
    paddr = 12'h004; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF; penable = 1'b0;
    psel_v[2] = 1'b1;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midreset_pready", {31'd0, pready_v[2]}, 32'd0);
    chk("midreset_regout", regout_v[2][31:0], 32'd0);
    psel_v[2] = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(2, 12'h024, 1'b0, 32'h0, 4'hF, rd, er, waits, idle_bad);
    chk("midreset_cnt", rd, 32'd0);
    xfer(2, 12'h004, 1'b0, 32'h0, 4'hF, rd, er, waits, idle_bad);
    chk("midreset_target", rd, 32'd0);
    chk("midreset_target_err", {31'd0, er}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
